// File: rtl/aud_i2s_recorder.sv
// WM8731 record path: synchronise the I2S ADC pins, capture the left channel
// of each frame and write it to consecutive SRAM words starting at address 0.
module aud_i2s_recorder #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = 20'hFFFFF,
    parameter int              SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_AUD_BCLK,
    input  logic              i_AUD_ADCLRCK,
    input  logic              i_AUD_ADCDAT,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [DATA_W-1:0] o_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_busy,
    output logic              o_full,
    output logic [2:0]        o_state
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_LR = 3'd1,
        ST_SKIP    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_PAUSED  = 3'd5,
        ST_FULL    = 3'd6
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0] bclk_sync_r, lrck_sync_r, dat_sync_r;
    logic                   bclk_d_r, lrck_d_r;
    logic                   bclk_rise_s, lr_fall_s, dat_s;
    logic [DATA_W-1:0]      sample_r;
    logic [BW-1:0]          bitcnt_r;
    logic [1:0]             wr_ph_r;
    logic                   pause_pend_r;
    logic [ADDR_W-1:0]      addr_r;

    // Equal-length chains keep BCLK, LRCK and DAT aligned to each other.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_sync_r <= '0;
            lrck_sync_r <= '0;
            dat_sync_r  <= '0;
            bclk_d_r    <= 1'b0;
            lrck_d_r    <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i_AUD_BCLK};
            lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], i_AUD_ADCLRCK};
            dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], i_AUD_ADCDAT};
            bclk_d_r    <= bclk_sync_r[SYNC_STAGES-1];
            lrck_d_r    <= lrck_sync_r[SYNC_STAGES-1];
        end
    end

    assign bclk_rise_s = bclk_sync_r[SYNC_STAGES-1] & ~bclk_d_r;
    assign lr_fall_s   = ~lrck_sync_r[SYNC_STAGES-1] & lrck_d_r;
    assign dat_s       = dat_sync_r[SYNC_STAGES-1];

    // Next-state decode; stop beats pause beats start.
    always_comb begin
        state_nxt_s = state_r;
        if (i_stop) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    if (i_start) state_nxt_s = ST_WAIT_LR; else state_nxt_s = ST_IDLE;
                ST_WAIT_LR: if (i_pause) state_nxt_s = ST_PAUSED;
                            else if (lr_fall_s) state_nxt_s = ST_SKIP;
                            else state_nxt_s = ST_WAIT_LR;
                ST_SKIP:    if (i_pause) state_nxt_s = ST_PAUSED;
                            else if (bclk_rise_s) state_nxt_s = ST_SHIFT;
                            else state_nxt_s = ST_SKIP;
                ST_SHIFT:   if (i_pause) state_nxt_s = ST_PAUSED;
                            else if (bclk_rise_s && (bitcnt_r == LAST_BIT)) state_nxt_s = ST_WRITE;
                            else state_nxt_s = ST_SHIFT;
                ST_WRITE:   if (wr_ph_r != 2'd2) state_nxt_s = ST_WRITE;
                            else if (addr_r == MAX_ADDR) state_nxt_s = ST_FULL;
                            else if (pause_pend_r || i_pause) state_nxt_s = ST_PAUSED;
                            else state_nxt_s = ST_WAIT_LR;
                ST_PAUSED:  if (i_pause || i_start) state_nxt_s = ST_WAIT_LR; else state_nxt_s = ST_PAUSED;
                ST_FULL:    if (i_start) state_nxt_s = ST_WAIT_LR; else state_nxt_s = ST_FULL;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Capture/write FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            sample_r     <= '0;
            bitcnt_r     <= '0;
            wr_ph_r      <= 2'd0;
            pause_pend_r <= 1'b0;
            addr_r       <= '0;
            o_SRAM_ADDR  <= '0;
            o_SRAM_DQ    <= '0;
            o_SRAM_WE_N  <= 1'b1;
            o_rec_len    <= '0;
            o_busy       <= 1'b0;
            o_full       <= 1'b0;
            o_state      <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            o_state <= state_nxt_s;
            o_busy  <= (state_nxt_s == ST_WAIT_LR) || (state_nxt_s == ST_SKIP) ||
                       (state_nxt_s == ST_SHIFT)   || (state_nxt_s == ST_WRITE);
            o_full  <= (state_nxt_s == ST_FULL);
            if (i_stop) begin
                // An interrupted write is abandoned: strobe released, length untouched.
                o_SRAM_WE_N  <= 1'b1;
                wr_ph_r      <= 2'd0;
                pause_pend_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_FULL: begin
                        if (i_start) begin
                            addr_r    <= '0;
                            o_rec_len <= '0;
                        end
                    end
                    ST_SKIP: begin
                        if (bclk_rise_s) bitcnt_r <= '0;
                    end
                    ST_SHIFT: begin
                        if (bclk_rise_s && !i_pause) begin
                            sample_r <= {sample_r[DATA_W-2:0], dat_s};
                            bitcnt_r <= bitcnt_r + 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (i_pause) pause_pend_r <= 1'b1;
                        case (wr_ph_r)
                            2'd0: begin
                                o_SRAM_ADDR <= addr_r;
                                o_SRAM_DQ   <= sample_r;
                                wr_ph_r     <= 2'd1;
                            end
                            2'd1: begin
                                o_SRAM_WE_N <= 1'b0;
                                wr_ph_r     <= 2'd2;
                            end
                            2'd2: begin
                                o_SRAM_WE_N  <= 1'b1;
                                o_rec_len    <= o_rec_len + 1'b1;
                                wr_ph_r      <= 2'd0;
                                pause_pend_r <= 1'b0;
                                if (addr_r != MAX_ADDR) addr_r <= addr_r + 1'b1;
                            end
                            default: wr_ph_r <= 2'd0;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Self-checking bench: I2S source model plus a write scoreboard for aud_i2s_recorder.
module tb_aud_i2s_recorder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic        bclk = 1'b1, lrck = 1'b1, dat = 1'b0;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        sram_we_n;
    logic [20:0] rec_len;
    logic        busy, full;
    logic [2:0]  state;

    int n_checks = 0;
    int errors   = 0;
    int we_cnt   = 0;

    typedef struct { logic [19:0] addr; logic [15:0] dq; } wr_t;
    wr_t exp_q[$];

    aud_i2s_recorder #(.MAX_ADDR(20'd3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .o_SRAM_ADDR(sram_addr), .o_SRAM_DQ(sram_dq), .o_SRAM_WE_N(sram_we_n),
        .o_rec_len(rec_len), .o_busy(busy), .o_full(full), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every WE_N-low cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && sram_we_n == 1'b0) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check_val("wr_addr", 32'(sram_addr), 32'(w.addr));
                check_val("wr_dq", 32'(sram_dq), 32'(w.dq));
            end
        end
    end

    task automatic push_wr(input logic [19:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.dq   = d;
        exp_q.push_back(w);
    endtask

    // One I2S frame, 32 slots per channel, data one slot after the LRCK edge.
    task automatic send_frame(input logic [15:0] left, input logic [15:0] right);
        logic [15:0] word;
        for (int ch = 0; ch < 2; ch++) begin
            word = (ch == 0) ? left : right;
            for (int s = 0; s < 32; s++) begin
                bclk = 1'b0;
                lrck = (ch == 1);
                dat  = (s >= 1 && s <= 16) ? word[16-s] : 1'b0;
                #40;
                bclk = 1'b1;
                #40;
            end
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) start = 1'b1;
        else if (which == 1) pause = 1'b1;
        else if (which == 2) stop = 1'b1;
        else begin stop = 1'b1; pause = 1'b1; end
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    initial begin
        logic [15:0] t2 [3];
        int k;
        t2[0] = 16'h0001; t2[1] = 16'h8000; t2[2] = 16'h7FFF;

        repeat (3) @(negedge clk);
        check_val("rst_we_n", 32'(sram_we_n), 32'd1);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_len", 32'(rec_len), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single frame
        pulse(0);
        check_val("t1_busy", 32'(busy), 32'd1);
        push_wr(20'd0, 16'hA5C3);
        send_frame(16'hA5C3, 16'hFFFF);
        check_val("t1_len", 32'(rec_len), 32'd1);
        check_val("t1_we_cnt", 32'(we_cnt), 32'd1);
        check_val("t1_state", 32'(state), 32'd1);

        // 2: three frames in a fresh recording
        pulse(2);
        check_val("t2_stop_len_kept", 32'(rec_len), 32'd1);
        pulse(0);
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            push_wr(20'(i), t2[i]);
            send_frame(t2[i], 16'h1234);
        end
        check_val("t2_len", 32'(rec_len), 32'd3);
        check_val("t2_we_cnt", 32'(we_cnt), 32'd3);

        // 3: pause mid-sample discards it
        pulse(2);
        pulse(0);
        push_wr(20'd0, 16'h1234);
        send_frame(16'h1234, 16'h0000);
        fork
            send_frame(16'hDEAD, 16'h0000);
            begin
                #(8*80 + 20);
                pulse(1);
                check_val("t3_paused", 32'(state), 32'd5);
                check_val("t3_busy", 32'(busy), 32'd0);
            end
        join
        pulse(1);
        check_val("t3_resume", 32'(state), 32'd1);
        push_wr(20'd1, 16'hBEEF);
        send_frame(16'hBEEF, 16'h0000);
        check_val("t3_len", 32'(rec_len), 32'd2);

        // 4: fill to MAX_ADDR=3
        pulse(2);
        pulse(0);
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) push_wr(20'(i), 16'(16'h1100 + i));
            send_frame(16'(16'h1100 + i), 16'hFFFF);
        end
        check_val("t4_full", 32'(full), 32'd1);
        check_val("t4_state", 32'(state), 32'd6);
        check_val("t4_len", 32'(rec_len), 32'd4);
        check_val("t4_we_cnt", 32'(we_cnt), 32'd4);
        pulse(1);
        check_val("t4_pause_ignored", 32'(state), 32'd6);
        pulse(0);
        check_val("t4_restart_len", 32'(rec_len), 32'd0);
        push_wr(20'd0, 16'h4321);
        send_frame(16'h4321, 16'h0000);
        check_val("t4_restart_len1", 32'(rec_len), 32'd1);

        // 5: stop during WRITE c1
        we_cnt = 0;
        fork
            send_frame(16'h7777, 16'h0000);
            begin
                k = 0;
                while (state != 3'd4 && k < 1500) begin
                    @(negedge clk);
                    k++;
                end
                check_val("t5_reach_write", 32'(state), 32'd4);
                @(negedge clk);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                check_val("t5_idle", 32'(state), 32'd0);
                check_val("t5_we_n", 32'(sram_we_n), 32'd1);
                check_val("t5_len", 32'(rec_len), 32'd1);
            end
        join
        check_val("t5_no_write", 32'(we_cnt), 32'd0);
        pulse(0);
        check_val("t5_started", 32'(state), 32'd1);
        pulse(3);
        check_val("t5_stop_pause", 32'(state), 32'd0);

        // 6: reset while WE_N is low
        pulse(0);
        push_wr(20'd0, 16'h5A5A);
        fork
            send_frame(16'h5A5A, 16'h0000);
            begin
                k = 0;
                @(negedge clk);
                while (sram_we_n != 1'b0 && k < 1500) begin
                    @(negedge clk);
                    k++;
                end
                check_val("t6_we_low", 32'(sram_we_n), 32'd0);
                #2;
                rst = 1'b1;
                #1;
                check_val("t6_we_n", 32'(sram_we_n), 32'd1);
                check_val("t6_state", 32'(state), 32'd0);
                check_val("t6_addr", 32'(sram_addr), 32'd0);
                check_val("t6_dq", 32'(sram_dq), 32'd0);
                check_val("t6_len", 32'(rec_len), 32'd0);
                check_val("t6_busy", 32'(busy), 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
